// File: rtl/axi_master_pkg.sv
// rtl/axi_master_pkg.sv - shared AXI widths, state encoding and response/burst constants
`ifndef AXI_ID_BITS
`define AXI_ID_BITS   4
`define AXI_ADDR_BITS 32
`define AXI_LEN_BITS  4
`define AXI_SIZE_BITS 3
`define AXI_DATA_BITS 32
`define AXI_STRB_BITS 4
`endif

package axi_master_pkg;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_WORD     = 3'b010;
endpackage

// File: rtl/axi_master_wrapper.sv
// rtl/axi_master_wrapper.sv - CPU port to AXI4 master, single writes and 1-16 beat INCR reads
// One transaction outstanding; every VALID/READY is a pure decode of the state register.
module axi_master_wrapper
  import axi_master_pkg::*;
#(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
  input  logic                      clk,
  input  logic                      ARSTN,
  input  logic                      core_req,
  input  logic                      core_we,
  input  logic [`AXI_ADDR_BITS-1:0] core_addr,
  input  logic [`AXI_LEN_BITS-1:0]  core_len,
  input  logic [`AXI_DATA_BITS-1:0] core_wdata,
  input  logic [`AXI_STRB_BITS-1:0] core_wstrb,
  output logic                      core_busy,
  output logic [`AXI_DATA_BITS-1:0] core_rdata,
  output logic                      core_rvalid,
  output logic                      core_done,
  output logic                      core_err,
  output logic [`AXI_ID_BITS-1:0]   M_AWID,
  output logic [`AXI_ADDR_BITS-1:0] M_AWADDR,
  output logic [`AXI_LEN_BITS-1:0]  M_AWLEN,
  output logic [`AXI_SIZE_BITS-1:0] M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [`AXI_DATA_BITS-1:0] M_WDATA,
  output logic [`AXI_STRB_BITS-1:0] M_WSTRB,
  output logic                      M_WLAST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [`AXI_ID_BITS-1:0]   M_BID,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [`AXI_ID_BITS-1:0]   M_ARID,
  output logic [`AXI_ADDR_BITS-1:0] M_ARADDR,
  output logic [`AXI_LEN_BITS-1:0]  M_ARLEN,
  output logic [`AXI_SIZE_BITS-1:0] M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [`AXI_ID_BITS-1:0]   M_RID,
  input  logic [`AXI_DATA_BITS-1:0] M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RLAST,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  state_e                    state_q, state_d;
  logic [`AXI_ADDR_BITS-1:0] addr_q, addr_d;
  logic [`AXI_LEN_BITS-1:0]  len_q, len_d;
  logic [`AXI_LEN_BITS-1:0]  cnt_q, cnt_d;
  logic [`AXI_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [`AXI_STRB_BITS-1:0] wstrb_q, wstrb_d;
  logic                      err_q, err_d;
  logic                      beat_err;

  // IDs are not checked with a single transaction in flight; low address bits are forced to 0.
  logic unused_ok;
  assign unused_ok = ^{M_RID, M_BID, core_addr[1:0]};

  always_ff @(posedge clk or posedge ARSTN) begin
    if (ARSTN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
    end
  end

  assign M_ARVALID = (state_q == AR);
  assign M_RREADY  = (state_q == R);
  assign M_AWVALID = (state_q == AW);
  assign M_WVALID  = (state_q == W);
  assign M_BREADY  = (state_q == B);
  assign core_busy = (state_q != IDLE);

  assign M_ARID    = MASTER_ID;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = len_q;
  assign M_ARSIZE  = SIZE_WORD;
  assign M_ARBURST = BURST_INCR;
  assign M_AWID    = MASTER_ID;
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = '0;
  assign M_AWSIZE  = SIZE_WORD;
  assign M_AWBURST = BURST_INCR;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_WLAST   = 1'b1;
  assign core_rdata = M_RDATA;

  assign beat_err = (M_RRESP != AXI_RESP_OKAY);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    err_d       = err_q;
    core_rvalid = 1'b0;
    core_done   = 1'b0;
    core_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req) begin
          addr_d = {core_addr[`AXI_ADDR_BITS-1:2], 2'b00};
          if (core_we) begin
            wdata_d = core_wdata;
            wstrb_d = core_wstrb;
            state_d = AW;
          end else begin
            len_d   = core_len;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = AR;
          end
        end
      end
      AR: if (M_ARREADY) state_d = R;
      R: begin
        if (M_RVALID) begin
          core_rvalid = 1'b1;
          if (M_RLAST) begin
            core_done = 1'b1;
            core_err  = err_q | beat_err | (cnt_q != len_q);
            state_d   = IDLE;
          end else begin
            if (beat_err) err_d = 1'b1;
            // Overrun: count saturates at len and the burst is flagged, waiting for RLAST.
            if (cnt_q == len_q) err_d = 1'b1;
            else cnt_d = cnt_q + {{(`AXI_LEN_BITS-1){1'b0}}, 1'b1};
          end
        end
      end
      AW: if (M_AWREADY) state_d = W;
      W:  if (M_WREADY) state_d = B;
      B: begin
        if (M_BVALID) begin
          core_done = 1'b1;
          core_err  = (M_BRESP != AXI_RESP_OKAY);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_wrapper.sv
// tb/tb_axi_master_wrapper.sv - scoreboard bench for axi_master_wrapper
`ifndef AXI_ID_BITS
`define AXI_ID_BITS   4
`define AXI_ADDR_BITS 32
`define AXI_LEN_BITS  4
`define AXI_SIZE_BITS 3
`define AXI_DATA_BITS 32
`define AXI_STRB_BITS 4
`endif

module tb_axi_master_wrapper;
  logic        clk = 1'b0;
  logic        ARSTN = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [3:0]  core_len = '0, core_wstrb = '0;
  logic        core_busy, core_rvalid, core_done, core_err;
  logic [31:0] core_rdata;
  logic [3:0]  M_AWID, M_AWLEN, M_ARID, M_ARLEN, M_WSTRB;
  logic [31:0] M_AWADDR, M_ARADDR, M_WDATA;
  logic [2:0]  M_AWSIZE, M_ARSIZE;
  logic [1:0]  M_AWBURST, M_ARBURST;
  logic        M_AWVALID, M_WLAST, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic        M_AWREADY = 0, M_WREADY = 0, M_BVALID = 0, M_ARREADY = 0;
  logic        M_RLAST = 0, M_RVALID = 0;
  logic [1:0]  M_BRESP = 0, M_RRESP = 0;
  logic [31:0] M_RDATA = '0;

  always #5 clk = ~clk;

  axi_master_wrapper #(.MASTER_ID(4'd0)) dut (
    .clk(clk), .ARSTN(ARSTN),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_len(core_len),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_busy(core_busy),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid), .core_done(core_done), .core_err(core_err),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(4'd0), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(4'd0), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  localparam int K_AR = 0, K_AW = 1, K_W = 2, K_RB = 3, K_DONE = 4;
  typedef struct { int kind; logic [31:0] a; logic [31:0] b; } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: kind %0d a=%h b=%h with nothing expected", kind, a, b);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.a !== a || e.b !== b) begin
      errors++;
      $display("FAIL sb_kind%0d: got kind %0d a=%h b=%h expected kind %0d a=%h b=%h",
               e.kind, kind, a, b, e.kind, e.a, e.b);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b;
    return e;
  endfunction

  // Monitor: compares every DUT output event against the expected stream, in fixed per-cycle order.
  always @(negedge clk) begin
    if (!ARSTN) begin
      if (M_ARVALID && M_ARREADY) sb_pop(K_AR, M_ARADDR, 32'({M_ARLEN, M_ARSIZE, M_ARBURST}));
      if (M_AWVALID && M_AWREADY) sb_pop(K_AW, M_AWADDR, 32'({M_AWLEN, M_AWSIZE, M_AWBURST}));
      if (M_WVALID && M_WREADY)   sb_pop(K_W, M_WDATA, 32'({M_WSTRB, M_WLAST}));
      if (core_rvalid)            sb_pop(K_RB, core_rdata, 32'd0);
      if (core_done)              sb_pop(K_DONE, 32'(core_err), 32'd0);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] wd, input logic [3:0] ws);
    core_req = 1; core_we = we; core_addr = addr; core_len = len; core_wdata = wd; core_wstrb = ws;
    tick();
    core_req = 0;
    chk("busy_after_req", 32'(core_busy), 32'd1);
  endtask

  task automatic do_ar(input int delay, input logic [31:0] exp_addr, input logic [3:0] exp_len);
    int n = 0;
    exp_q.push_back(mk(K_AR, exp_addr, 32'({exp_len, 3'b010, 2'b01})));
    while (!M_ARVALID && n < 50) begin tick(); n++; end
    chk("arvalid_latency", 32'(n), 32'd0);
    repeat (delay) tick();
    M_ARREADY = 1; tick(); M_ARREADY = 0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                        input logic exp_done, input logic exp_err);
    exp_q.push_back(mk(K_RB, d, 32'd0));
    if (exp_done) exp_q.push_back(mk(K_DONE, 32'(exp_err), 32'd0));
    M_RVALID = 1; M_RDATA = d; M_RRESP = resp; M_RLAST = last;
    tick();
    M_RVALID = 0; M_RLAST = 0; M_RRESP = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_delay, input logic [1:0] bresp);
    int n = 0;
    start_req(1'b1, addr, 4'd0, wd, ws);
    exp_q.push_back(mk(K_AW, exp_addr, 32'({4'd0, 3'b010, 2'b01})));
    while (!M_AWVALID && n < 50) begin tick(); n++; end
    chk("awvalid_latency", 32'(n), 32'd0);
    for (int i = 0; i < aw_delay; i++) begin
      chk("wvalid_before_aw", 32'(M_WVALID), 32'd0);
      tick();
    end
    M_AWREADY = 1; tick(); M_AWREADY = 0;
    exp_q.push_back(mk(K_W, wd, 32'({ws, 1'b1})));
    n = 0;
    while (!M_WVALID && n < 50) begin tick(); n++; end
    chk("wvalid_latency", 32'(n), 32'd0);
    M_WREADY = 1; tick(); M_WREADY = 0;
    exp_q.push_back(mk(K_DONE, 32'(bresp != 2'b00), 32'd0));
    n = 0;
    while (!M_BREADY && n < 50) begin tick(); n++; end
    chk("bready_latency", 32'(n), 32'd0);
    M_BVALID = 1; M_BRESP = bresp; tick(); M_BVALID = 0; M_BRESP = 0;
    chk("idle_after_write", 32'(core_busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk("rst_valids", 32'({M_ARVALID, M_AWVALID, M_WVALID, M_BREADY, M_RREADY}), 32'd0);
    chk("rst_core", 32'({core_busy, core_rvalid, core_done, core_err}), 32'd0);
    chk("rst_araddr", M_ARADDR, 32'd0);
    #1 ARSTN = 0;
    tick();

    // Single read
    start_req(1'b0, 32'h0000_1004, 4'd0, '0, '0);
    do_ar(2, 32'h0000_1004, 4'd0);
    r_beat(32'hDEAD_BEEF, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("idle_after_read", 32'(core_busy), 32'd0);
    tick();

    // Gapped burst of 4
    start_req(1'b0, 32'h0000_0100, 4'd3, '0, '0);
    do_ar(0, 32'h0000_0100, 4'd3);
    r_beat(32'hA000_0000, 2'b00, 1'b0, 1'b0, 1'b0);
    r_beat(32'hA000_0001, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    r_beat(32'hA000_0002, 2'b00, 1'b0, 1'b0, 1'b0);
    r_beat(32'hA000_0003, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();

    do_write(32'h0000_2000, 32'h0000_2000, 32'h1234_5678, 4'b0011, 3, 2'b00);
    tick();

    // SLVERR on beat 1 of 2
    start_req(1'b0, 32'h0000_0200, 4'd1, '0, '0);
    do_ar(1, 32'h0000_0200, 4'd1);
    r_beat(32'h0000_00B0, 2'b00, 1'b0, 1'b0, 1'b0);
    r_beat(32'h0000_00B1, 2'b10, 1'b1, 1'b1, 1'b1);
    tick();

    do_write(32'h0000_2006, 32'h0000_2004, 32'hCAFE_0001, 4'b1111, 0, 2'b11);
    tick();

    // Early RLAST on beat 1 of 4
    start_req(1'b0, 32'h0000_0300, 4'd3, '0, '0);
    do_ar(0, 32'h0000_0300, 4'd3);
    r_beat(32'h0000_00C0, 2'b00, 1'b0, 1'b0, 1'b0);
    r_beat(32'h0000_00C1, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("idle_after_early_last", 32'(core_busy), 32'd0);
    tick();

    // Missing RLAST on beat 3 of 4, late RLAST on a fifth beat
    start_req(1'b0, 32'h0000_0400, 4'd3, '0, '0);
    do_ar(0, 32'h0000_0400, 4'd3);
    for (int i = 0; i < 4; i++) r_beat(32'h0000_00D0 + 32'(i), 2'b00, 1'b0, 1'b0, 1'b0);
    chk("busy_after_overrun", 32'(core_busy), 32'd1);
    r_beat(32'h0000_00D4, 2'b00, 1'b1, 1'b1, 1'b1);
    tick();

    // Reset during beat 2 of 4
    start_req(1'b0, 32'h0000_5000, 4'd3, '0, '0);
    do_ar(0, 32'h0000_5000, 4'd3);
    r_beat(32'h0000_00E0, 2'b00, 1'b0, 1'b0, 1'b0);
    r_beat(32'h0000_00E1, 2'b00, 1'b0, 1'b0, 1'b0);
    M_RVALID = 1; M_RDATA = 32'h0000_00E2;
    #1 ARSTN = 1;
    #1;
    chk("midrst_valids", 32'({M_ARVALID, M_AWVALID, M_WVALID, M_BREADY, M_RREADY}), 32'd0);
    chk("midrst_core", 32'({core_busy, core_rvalid, core_done}), 32'd0);
    tick();
    M_RVALID = 0;
    tick();
    ARSTN = 0;
    tick();

    // Read after reset, unaligned address
    start_req(1'b0, 32'h0000_3007, 4'd0, '0, '0);
    do_ar(0, 32'h0000_3004, 4'd0);
    r_beat(32'hCAFE_F00D, 2'b00, 1'b1, 1'b1, 1'b0);
    tick(); tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
